// File: rtl/dmem_dump_ctrl.sv
// dmem_dump_ctrl
// Walks an inclusive, wrapping address window of the data memory through the
// shared read port and streams {address, data} beats on a valid/ready channel.
// The core keeps priority on the read port, so the dump only uses idle cycles.

module dmem_dump_ctrl #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] first_addr,
   input  logic [AW-1:0] last_addr,
   input  logic          core_access,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [AW-1:0] dump_addr,
   output logic [DW-1:0] dump_data,
   output logic          dump_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND
   } state_t;

   state_t        state_q,     state_d;
   logic [AW-1:0] cur_addr_q,  cur_addr_d;
   logic [AW:0]   remaining_q, remaining_d;
   logic [AW-1:0] dump_addr_q, dump_addr_d;
   logic [DW-1:0] dump_data_q, dump_data_d;
   logic          dump_last_q, dump_last_d;
   logic          done_q,      done_d;

   logic [AW:0]   span_c;       // (last - first) mod DEPTH
   logic [AW-1:0] next_addr_c;  // cur_addr + 1 with wrap at DEPTH-1

   // Window length minus one and the wrapping address increment.
   always_comb begin
      if (last_addr >= first_addr) begin
         span_c = {1'b0, last_addr} - {1'b0, first_addr};
      end else begin
         span_c = {1'b0, last_addr} + (AW+1)'(DEPTH) - {1'b0, first_addr};
      end
      if (cur_addr_q == AW'(DEPTH - 1)) begin
         next_addr_c = '0;
      end else begin
         next_addr_c = cur_addr_q + AW'(1);
      end
   end

   // Next-state logic: sequence READ -> WAIT -> SEND per word, abort wins.
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves a value unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      dump_addr_d = dump_addr_q;
      dump_data_d = dump_data_q;
      dump_last_d = dump_last_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               cur_addr_d  = first_addr;
               remaining_d = span_c + (AW+1)'(1);
               state_d     = S_READ;
            end
         end
         S_READ: begin
            // The core owns the port this cycle; retry next cycle.
            if (!core_access) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Read data arrives one cycle after the strobe.
            dump_data_d = mem_rdata;
            dump_addr_d = cur_addr_q;
            dump_last_d = (remaining_q == (AW+1)'(1));
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (dump_ready) begin
               if (dump_last_q) begin
                  dump_last_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  cur_addr_d  = next_addr_c;
                  remaining_d = remaining_q - (AW+1)'(1);
                  state_d     = S_READ;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort drops the dump silently; any read in flight is never captured.
      if (abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         dump_last_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments keep all registers updating from
      // the same pre-edge values, independent of statement order.
      if (reset) begin
         // NOTE: the captured beat (including the data word) is reset so the
         // output channel is fully defined immediately after reset.
         state_q     <= S_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         dump_addr_q <= '0;
         dump_data_q <= '0;
         dump_last_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         dump_addr_q <= dump_addr_d;
         dump_data_q <= dump_data_d;
         dump_last_q <= dump_last_d;
         done_q      <= done_d;
      end
   end

   // Read-port and stream outputs; the strobe yields to the core.
   always_comb begin
      mem_rd_en  = (state_q == S_READ) && !core_access;
      mem_addr   = cur_addr_q;
      dump_valid = (state_q == S_SEND);
      dump_addr  = dump_addr_q;
      dump_data  = dump_data_q;
      dump_last  = dump_last_q;
      busy       = (state_q != S_IDLE);
      done       = done_q;
   end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Testbench for dmem_dump_ctrl: a behavioural memory, a stimulus process
// that pushes expected reads and beats into queues, and a monitor that pops
// and compares whenever the DUT strobes the memory or hands over a beat.

module tb_dmem_dump_ctrl;

   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [AW-1:0] first_addr;
   logic [AW-1:0] last_addr;
   logic          core_access;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          dump_valid;
   logic          dump_ready;
   logic [AW-1:0] dump_addr;
   logic [DW-1:0] dump_data;
   logic          dump_last;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   dmem_dump_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .core_access(core_access),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_last  (dump_last),
      .busy       (busy),
      .done       (done)
   );

   // Behavioural data memory with one-cycle read latency.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t         beat_q[$];
   logic [AW-1:0] rd_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            beats_seen = 0;
   bit            exp_busy = 1'b0;
   bit            pending_done = 1'b0;
   bit            rand_mode = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input string got, input string want);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, want, $time);
   endtask

   // Monitor: compares reads, beats, busy and done against the queued model.
   bit    hold_v = 1'b0;
   beat_t held;
   always @(negedge clk) begin : monitor
      beat_t e;
      logic [AW-1:0] ea;
      bit busy_now;
      if (reset) begin
         exp_busy     = 1'b0;
         pending_done = 1'b0;
         hold_v       = 1'b0;
      end else begin
         busy_now = exp_busy;
         check("busy", busy, exp_busy);
         check("done", done, pending_done);
         if (hold_v) begin
            check("stall_valid", dump_valid, 1);
            check("stall_addr",  dump_addr,  held.addr);
            check("stall_data",  dump_data,  held.data);
            check("stall_last",  dump_last,  held.last);
         end
         if (mem_rd_en) begin
            if (core_access) begin
               fail("rd_en_vs_core", "mem_rd_en=1 with core_access=1", "mem_rd_en=0");
            end else if (rd_q.size() == 0) begin
               fail("unexpected_read", $sformatf("read of addr %0d", mem_addr), "no read");
            end else begin
               ea = rd_q.pop_front();
               check("rd_addr", mem_addr, ea);
            end
         end
         pending_done = 1'b0;
         hold_v       = 1'b0;
         if (dump_valid && !dump_ready && !abort) begin
            hold_v = 1'b1;
            held   = '{addr: dump_addr, data: dump_data, last: dump_last};
         end
         if (dump_valid && dump_ready && !abort) begin
            if (beat_q.size() == 0) begin
               fail("unexpected_beat", $sformatf("beat addr %0d", dump_addr), "no beat");
            end else begin
               e = beat_q.pop_front();
               check("beat_addr", dump_addr, e.addr);
               check("beat_data", dump_data, e.data);
               check("beat_last", dump_last, e.last);
               beats_seen++;
               if (e.last) begin
                  pending_done = 1'b1;
                  exp_busy     = 1'b0;
               end
            end
         end
         if (busy_now && abort) exp_busy = 1'b0;
         if (!busy_now && start && !abort) exp_busy = 1'b1;
      end
   end

   // One clock step; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (rand_mode) begin
         core_access = ($urandom_range(0, 3) == 0);
         dump_ready  = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Queue the expected reads and beats of the window, then pulse start.
   task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
      int n;
      int a;
      tick();
      n = ((int'(l) - int'(f) + DEPTH) % DEPTH) + 1;
      for (int k = 0; k < n; k++) begin
         a = (int'(f) + k) % DEPTH;
         rd_q.push_back(AW'(a));
         beat_q.push_back('{addr: AW'(a), data: mem[a], last: (k == n - 1)});
      end
      first_addr = f;
      last_addr  = l;
      start      = 1'b1;
      tick();
   endtask

   task automatic flush();
      beat_q.delete();
      rd_q.delete();
   endtask

   task automatic wait_idle(input int budget, input string name);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (!busy && !done && beat_q.size() == 0 && rd_q.size() == 0) break;
         tick();
      end
      if (i == budget) fail(name, "dump still pending", "dump complete");
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_busy"},  busy,       0);
      check({name, "_done"},  done,       0);
      check({name, "_valid"}, dump_valid, 0);
      check({name, "_last"},  dump_last,  0);
      check({name, "_daddr"}, dump_addr,  0);
      check({name, "_ddata"}, dump_data,  0);
      check({name, "_rden"},  mem_rd_en,  0);
      check({name, "_maddr"}, mem_addr,   0);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      int b0;
      reset       = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      first_addr  = '0;
      last_addr   = '0;
      core_access = 1'b0;
      dump_ready  = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Full 32-word dump, no contention: done in cycle index 97 after start.
      dump_ready = 1'b1;
      b0 = beats_seen;
      start_dump(5'd0, 5'd31);
      n = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) break;
         tick();
         n++;
      end
      check("full_done_cycle", n, 97);
      wait_idle(50, "full_idle");
      check("full_beats", beats_seen - b0, 32);

      // Wrapping window, then a single word followed by a start in the done cycle.
      start_dump(5'd30, 5'd1);
      wait_idle(100, "wrap_idle");
      start_dump(5'd7, 5'd7);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (dump_valid && dump_ready) break;
         tick();
      end
      start_dump(5'd3, 5'd4);
      wait_idle(100, "b2b_idle");

      // Core contention: five cycles of core_access in READ delay the beat by 5.
      start_dump(5'd10, 5'd11);
      core_access = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("contend_rd_en_low", mem_rd_en, 0);
         tick();
      end
      core_access = 1'b0;
      @(negedge clk);
      check("contend_rd_en_high", mem_rd_en, 1);
      n = 6;
      while (!dump_valid && n < 50) begin
         tick();
         n++;
         @(negedge clk);
      end
      check("contend_first_valid_cycle", n, 8);
      wait_idle(100, "contend_idle");

      // Backpressure on the third beat for four cycles.
      b0 = beats_seen;
      start_dump(5'd20, 5'd27);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (beats_seen - b0 >= 2) break;
         tick();
      end
      tick();
      dump_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (dump_valid) break;
         tick();
      end
      check("bp_addr", dump_addr, 22);
      repeat (4) tick();
      dump_ready = 1'b1;
      wait_idle(100, "bp_idle");
      check("bp_beats", beats_seen - b0, 8);

      // Start while busy is ignored; the address sequence continues.
      start_dump(5'd0, 5'd7);
      repeat (4) tick();
      first_addr = 5'd15;
      last_addr  = 5'd16;
      start      = 1'b1;
      tick();
      wait_idle(100, "busy_start_idle");

      // Abort in SEND with ready high: no handshake, no done, port stays quiet.
      dump_ready = 1'b0;
      start_dump(5'd5, 5'd10);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (dump_valid) break;
         tick();
      end
      tick();
      abort      = 1'b1;
      dump_ready = 1'b1;
      tick();
      flush();
      dump_ready = 1'b0;
      @(negedge clk);
      check("abort_valid", dump_valid, 0);
      check("abort_busy",  busy,       0);
      check("abort_last",  dump_last,  0);
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clk);
         check("abort_rd_en", mem_rd_en, 0);
      end

      // start together with abort in IDLE starts nothing.
      tick();
      start = 1'b1;
      abort = 1'b1;
      repeat (6) tick();
      @(negedge clk);
      check("start_abort_busy", busy, 0);

      // Reset asserted while in WAIT: everything returns to zero at once.
      dump_ready = 1'b1;
      start_dump(5'd12, 5'd15);
      tick();
      #1;
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      flush();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         @(negedge clk);
         check("post_reset_rd_en", mem_rd_en, 0);
         check("post_reset_valid", dump_valid, 0);
      end

      // Randomized windows, memory contents, contention, backpressure, aborts.
      rand_mode = 1'b1;
      for (int t = 0; t < 15; t++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
         start_dump(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 20)) tick();
            abort = 1'b1;
            tick();
            flush();
         end
         wait_idle(2000, "rand_idle");
      end
      rand_mode   = 1'b0;
      core_access = 1'b0;
      dump_ready  = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_dump_ctrl.md
# dmem_dump_ctrl

Sequencer that walks an inclusive address window of the 32-word data memory, reads each word through the memory's single read port and streams {address, data} out on a valid/ready channel. It sits beside the data-memory debug view in the SoC and feeds the debug/UART dump path. The core always keeps priority on the shared read port; the dump only steals idle cycles.

## Interface
- DEPTH, 32, number of data-memory words
- AW, 5, address width (log2 DEPTH)
- DW, 32, data width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- abort  in  1  terminate the current dump immediately
- first_addr  in  AW  first word index, latched on accepted start
- last_addr  in  AW  last word index (inclusive), latched on accepted start
- core_access  in  1  core uses the memory read port this cycle
- mem_rd_en  out  1  read strobe to the data memory
- mem_addr  out  AW  read address
- mem_rdata  in  DW  read data; valid the cycle after mem_rd_en
- dump_valid  out  1  output beat valid
- dump_ready  in  1  sink accepts beat
- dump_addr  out  AW  word index of the current beat
- dump_data  out  DW  word value of the current beat
- dump_last  out  1  current beat is the final one of the window
- busy  out  1  dump in progress (state != IDLE)
- done  out  1  one-cycle pulse after the final beat handshake

## Operation
- FSM states: IDLE, READ, WAIT, SEND.
- IDLE: on start && !abort, latch first_addr into cur_addr and remaining = ((last_addr - first_addr) mod DEPTH) + 1, then go to READ. first==last gives 1 word; last = first-1 (mod 32) gives 32 words.
- READ: mem_rd_en = !core_access; mem_addr = cur_addr. If core_access is high, stay in READ. Otherwise go to WAIT.
- WAIT: register mem_rdata into dump_data, cur_addr into dump_addr, and (remaining==1) into dump_last; go to SEND.
- SEND: dump_valid = 1. On dump_ready:
  - if dump_last: go to IDLE and pulse done.
  - otherwise: cur_addr = cur_addr+1 (wraps 31 -> 0), remaining decrements, go to READ.
- Without a handshake, dump_addr, dump_data and dump_last stay stable.
- mem_rd_en and mem_addr are combinational from state, cur_addr and core_access. mem_rd_en is never high outside READ.
- abort in any non-IDLE state: next state IDLE, dump_valid/dump_last clear, done not pulsed. Any in-flight read data is discarded.
- start while busy: ignored. start && abort in IDLE: no dump starts.
- remaining is AW+1 bits wide and holds 1..32.

## Timing
- Reset values: state IDLE, busy 0, done 0, dump_valid 0, dump_last 0, dump_addr 0, dump_data 0, mem_rd_en 0, mem_addr 0, internal counters 0.
- Reset asserted mid-dump: outputs take their reset values asynchronously; no done pulse.
- start sampled at edge N:
  - mem_rd_en high in cycle N+1 (if the port is free)
  - data captured at edge N+2
  - dump_valid high from cycle N+3
- Minimum of 3 cycles per word: READ, WAIT, SEND with ready high.
- Each core_access cycle during READ adds one cycle.
- Full 32-word dump with ready=1 and no contention: 96 cycles from start to final handshake.
- done is high for one cycle right after the final handshake edge; busy is 0 in that same cycle.
- A new start is accepted in the cycle done is high.

## Test plan
- Full dump: preload mem[i] = 0x100+i; first=0, last=31, ready=1 -> 32 beats with addr 0..31 and data 0x100..0x11F; dump_last only on addr 31; done 96 cycles after start edge plus one.
- Wrap and single word: first=30, last=1 -> beats at addr 30, 31, 0, 1 with last on 1. Then first=last=7 -> one beat, addr 7, last=1.
- Core contention: hold core_access for 5 cycles while in READ -> mem_rd_en stays 0 for 5 cycles, then 1; the beat is delayed by exactly 5 cycles and its data is correct.
- Backpressure: dump_ready low for 4 cycles on beat 3 -> valid held and addr/data/last stable; the stream continues after ready rises with no duplicate or lost beats.
- Abort and busy-start: start pulse mid-dump -> ignored (addresses continue in sequence). abort in SEND -> valid drops next cycle, busy 0, no done, no further mem_rd_en.
- Reset mid-dump: assert reset while in WAIT -> all outputs 0 immediately; after release, no activity until a new start.
